// File: rtl/writeback_unit.sv
// writeback_unit: final RV32I stage ahead of the register file.
// Accepts one retiring instruction per ex_valid/ex_ready handshake. A non-load
// writes its ALU result on the next cycle. A load waits in WAIT_MEM for the
// data-memory response, aligns and extends it by funct3, and then writes it.
// Misaligned loads, illegal funct3 values and timed-out loads raise a
// one-cycle load_err pulse, and the unit suppresses their write.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   ex_valid / ex_ready       retire handshake (ex_ready is combinational)
//   ex_wen, ex_is_load, ex_rd,
//   ex_result, ex_funct3,
//   ex_addr_lo                retiring instruction payload
//   mem_rvalid, mem_rdata     data-memory read response
//   reg_write, rd, write      registered register-file write port
//   load_err                  registered one-cycle load error pulse
module writeback_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_addr_lo,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic [31:0] reg_write,
    output logic [4:0]  rd,
    output logic        write,
    output logic        load_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       ld_rd, ld_rd_nxt;
    logic [2:0]       ld_funct3, ld_funct3_nxt;
    logic [1:0]       ld_addr_lo, ld_addr_lo_nxt;
    logic             ld_wen, ld_wen_nxt;
    logic [31:0]      reg_write_nxt;
    logic [4:0]       rd_nxt;
    logic             write_nxt;
    logic             load_err_nxt;

    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_data;
    logic             load_bad;

    assign ex_ready = (state == IDLE);

    // Select and extend the response using the latched load attributes
    always_comb begin
        load_byte = 8'd0;
        load_half = 16'd0;
        load_data = mem_rdata;
        load_bad  = 1'b0;
        case (ld_addr_lo)
            2'd0:    load_byte = mem_rdata[7:0];
            2'd1:    load_byte = mem_rdata[15:8];
            2'd2:    load_byte = mem_rdata[23:16];
            default: load_byte = mem_rdata[31:24];
        endcase
        load_half = ld_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (ld_funct3)
            3'd0: load_data = {{24{load_byte[7]}}, load_byte};
            3'd4: load_data = {24'd0, load_byte};
            3'd1: begin
                load_data = {{16{load_half[15]}}, load_half};
                load_bad  = ld_addr_lo[0];
            end
            3'd5: begin
                load_data = {16'd0, load_half};
                load_bad  = ld_addr_lo[0];
            end
            3'd2:    load_bad = (ld_addr_lo != 2'd0);
            default: load_bad = 1'b1;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        ld_rd_nxt      = ld_rd;
        ld_funct3_nxt  = ld_funct3;
        ld_addr_lo_nxt = ld_addr_lo;
        ld_wen_nxt     = ld_wen;
        reg_write_nxt  = reg_write;
        rd_nxt         = rd;
        write_nxt      = 1'b0;
        load_err_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_is_load) begin
                        ld_rd_nxt      = ex_rd;
                        ld_funct3_nxt  = ex_funct3;
                        ld_addr_lo_nxt = ex_addr_lo;
                        ld_wen_nxt     = ex_wen;
                        cnt_nxt        = '0;
                        state_nxt      = WAIT_MEM;
                    end else begin
                        reg_write_nxt = ex_result;
                        rd_nxt        = ex_rd;
                        write_nxt     = ex_wen && (ex_rd != 5'd0);
                    end
                end
            end
            WAIT_MEM: begin
                // A response on the final counted cycle still wins over timeout
                if (mem_rvalid) begin
                    reg_write_nxt = load_data;
                    rd_nxt        = ld_rd;
                    write_nxt     = !load_bad && ld_wen && (ld_rd != 5'd0);
                    load_err_nxt  = load_bad;
                    state_nxt     = IDLE;
                end else if (cnt == CNT_LAST) begin
                    load_err_nxt = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ld_rd      <= 5'd0;
            ld_funct3  <= 3'd0;
            ld_addr_lo <= 2'd0;
            ld_wen     <= 1'b0;
            reg_write  <= 32'd0;
            rd         <= 5'd0;
            write      <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            ld_rd      <= ld_rd_nxt;
            ld_funct3  <= ld_funct3_nxt;
            ld_addr_lo <= ld_addr_lo_nxt;
            ld_wen     <= ld_wen_nxt;
            reg_write  <= reg_write_nxt;
            rd         <= rd_nxt;
            write      <= write_nxt;
            load_err   <= load_err_nxt;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: table of retiring instructions with expected
// register-file events, checked through a scoreboard queue keyed by cycle.
module tb_writeback_unit;

    localparam int unsigned TO = 16;
    localparam int NV = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_wen, ex_is_load;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [2:0]  ex_funct3;
    logic [1:0]  ex_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] reg_write;
    logic [4:0]  rd;
    logic        write, load_err;

    writeback_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_wen(ex_wen),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_result(ex_result),
        .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .reg_write(reg_write), .rd(rd), .write(write), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // delay: cycles from transfer to the rvalid pulse; 0 means never (timeout)
    typedef struct {
        logic        is_load;
        logic        wen;
        logic [4:0]  rdi;
        logic [31:0] result;
        logic [2:0]  f3;
        logic [1:0]  alo;
        logic [31:0] rdata;
        int          delay;
        logic        ev;
        logic        ew;
        logic        ee;
        logic [31:0] ed;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        w;
        logic        e;
        logic        chk_rd;
        logic [4:0]  rdi;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[NV];
    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every write/load_err pulse must match the oldest expectation
    exp_t e;
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            check("missing_event_cycle", 32'(cyc), 32'(e.cyc));
        end
        if (write || load_err) begin
            if (q.size() == 0) begin
                check("unexpected_write", 32'(write), 32'd0);
                check("unexpected_load_err", 32'(load_err), 32'd0);
            end else begin
                e = q.pop_front();
                check("event_cycle", 32'(cyc), 32'(e.cyc));
                check("write", 32'(write), 32'(e.w));
                check("load_err", 32'(load_err), 32'(e.e));
                if (e.w) begin
                    check("rd", 32'(rd), 32'(e.rdi));
                    check("reg_write", reg_write, e.data);
                end
                if (e.chk_rd) check("err_rd", 32'(rd), 32'(e.rdi));
            end
        end
    end

    task automatic apply(input vec_t v);
        int k;
        @(negedge clk);
        ex_valid   = 1'b1;
        ex_is_load = v.is_load;
        ex_wen     = v.wen;
        ex_rd      = v.rdi;
        ex_result  = v.result;
        ex_funct3  = v.f3;
        ex_addr_lo = v.alo;
        mem_rdata  = v.rdata;
        check("ex_ready_idle", 32'(ex_ready), 32'd1);
        k = cyc + 1;
        if (v.ev) begin
            if (!v.is_load)
                q.push_back('{k, v.ew, v.ee, 1'b0, v.rdi, v.ed});
            else if (v.delay > 0)
                q.push_back('{k + v.delay, v.ew, v.ee, v.ee, v.rdi, v.ed});
            else
                q.push_back('{k + int'(TO), 1'b0, 1'b1, 1'b0, v.rdi, v.ed});
        end
        @(posedge clk);
        if (v.is_load) begin
            @(negedge clk);
            ex_valid = 1'b0;
            check("ex_ready_wait", 32'(ex_ready), 32'd0);
            if (v.delay > 0) begin
                repeat (v.delay - 1) @(negedge clk);
                mem_rvalid = 1'b1;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end else begin
                repeat (TO) @(negedge clk);
                check("ex_ready_after_timeout", 32'(ex_ready), 32'd1);
                mem_rvalid = 1'b1;   // stray response, must be ignored
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          ld   wen  rd     result         f3    alo   rdata          dly ev   ew   ee   exp data
        vecs[0]  = '{1'b0,1'b1,5'd5, 32'hDEADBEEF,3'd0,2'd0,32'h0,         0, 1'b1,1'b1,1'b0,32'hDEADBEEF};
        vecs[1]  = '{1'b0,1'b1,5'd1, 32'h11111111,3'd0,2'd0,32'h0,         0, 1'b1,1'b1,1'b0,32'h11111111};
        vecs[2]  = '{1'b0,1'b1,5'd2, 32'h22222222,3'd0,2'd0,32'h0,         0, 1'b1,1'b1,1'b0,32'h22222222};
        vecs[3]  = '{1'b0,1'b1,5'd3, 32'h33333333,3'd0,2'd0,32'h0,         0, 1'b1,1'b1,1'b0,32'h33333333};
        vecs[4]  = '{1'b0,1'b0,5'd7, 32'h77777777,3'd0,2'd0,32'h0,         0, 1'b0,1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b1,5'd0, 32'h55555555,3'd0,2'd0,32'h0,         0, 1'b0,1'b0,1'b0,32'h0};
        vecs[6]  = '{1'b1,1'b1,5'd8, 32'h0,       3'd0,2'd3,32'h80FF0000, 4, 1'b1,1'b1,1'b0,32'hFFFFFF80};
        vecs[7]  = '{1'b1,1'b1,5'd9, 32'h0,       3'd4,2'd3,32'h80FF0000, 4, 1'b1,1'b1,1'b0,32'h00000080};
        vecs[8]  = '{1'b1,1'b1,5'd10,32'h0,       3'd1,2'd1,32'h80FF0000, 2, 1'b1,1'b0,1'b1,32'h0};
        vecs[9]  = '{1'b1,1'b1,5'd11,32'h0,       3'd5,2'd2,32'hABCD1234, 1, 1'b1,1'b1,1'b0,32'h0000ABCD};
        vecs[10] = '{1'b1,1'b1,5'd12,32'h0,       3'd1,2'd0,32'h12348001, 3, 1'b1,1'b1,1'b0,32'hFFFF8001};
        vecs[11] = '{1'b1,1'b1,5'd13,32'h0,       3'd2,2'd0,32'hCAFEF00D, 3, 1'b1,1'b1,1'b0,32'hCAFEF00D};
        vecs[12] = '{1'b1,1'b1,5'd13,32'h0,       3'd2,2'd2,32'hCAFEF00D, 2, 1'b1,1'b0,1'b1,32'h0};
        vecs[13] = '{1'b1,1'b1,5'd14,32'h0,       3'd3,2'd0,32'h12345678, 1, 1'b1,1'b0,1'b1,32'h0};
        vecs[14] = '{1'b1,1'b1,5'd15,32'h0,       3'd7,2'd0,32'h12345678, 1, 1'b1,1'b0,1'b1,32'h0};
        vecs[15] = '{1'b1,1'b1,5'd16,32'h0,       3'd0,2'd1,32'h00007F00,16, 1'b1,1'b1,1'b0,32'h0000007F};
        vecs[16] = '{1'b1,1'b1,5'd17,32'h0,       3'd2,2'd0,32'h0BADBAD0, 0, 1'b1,1'b0,1'b1,32'h0};
        vecs[17] = '{1'b1,1'b0,5'd18,32'h0,       3'd2,2'd0,32'h11112222, 2, 1'b0,1'b0,1'b0,32'h0};
        vecs[18] = '{1'b1,1'b1,5'd0, 32'h0,       3'd2,2'd0,32'h33334444, 2, 1'b0,1'b0,1'b0,32'h0};
        vecs[19] = '{1'b1,1'b1,5'd19,32'h0,       3'd4,2'd2,32'h00C30000, 5, 1'b1,1'b1,1'b0,32'h000000C3};
        vecs[20] = '{1'b0,1'b1,5'd6, 32'h0000600D,3'd0,2'd0,32'h0,         0, 1'b1,1'b1,1'b0,32'h0000600D};

        rst = 1'b1;
        ex_valid = 1'b0; ex_is_load = 1'b0; ex_wen = 1'b0; ex_rd = 5'd0;
        ex_result = 32'd0; ex_funct3 = 3'd0; ex_addr_lo = 2'd0;
        mem_rvalid = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_write", 32'(write), 32'd0);
        check("reset_load_err", 32'(load_err), 32'd0);
        check("reset_rd", 32'(rd), 32'd0);
        check("reset_reg_write", reg_write, 32'd0);
        check("reset_ex_ready", 32'(ex_ready), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) apply(vecs[i]);
        @(negedge clk);
        ex_valid = 1'b0;

        // Reset in WAIT_MEM abandons the load; a later response is ignored
        @(negedge clk);
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd20;
        ex_funct3 = 3'd2; ex_addr_lo = 2'd0; mem_rdata = 32'h5A5A5A5A;
        @(posedge clk);
        @(negedge clk);
        ex_valid = 1'b0;
        check("rst_seq_waiting", 32'(ex_ready), 32'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_reg_write", reg_write, 32'd0);
        check("async_rst_rd", 32'(rd), 32'd0);
        check("async_rst_write", 32'(write), 32'd0);
        check("async_rst_ex_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;

        apply('{1'b0,1'b1,5'd0, 32'hFFFFFFFF,3'd0,2'd0,32'h0,0,1'b0,1'b0,1'b0,32'h0});
        apply('{1'b0,1'b1,5'd31,32'h31313131,3'd0,2'd0,32'h0,0,1'b1,1'b1,1'b0,32'h31313131});
        @(negedge clk);
        ex_valid = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
